// File: rtl/aurora_ctrl_pkg.sv
// Shared encodings for the Aurora lane bring-up/recovery sequencer.
package aurora_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_GT_RST    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RST       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_LANE = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_CHAN = 3'd3;
  localparam logic [STATE_W-1:0] ST_UP        = 3'd4;
  localparam logic [STATE_W-1:0] ST_BACKOFF   = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_GT_RST    = ST_GT_RST,
    S_RST       = ST_RST,
    S_WAIT_LANE = ST_WAIT_LANE,
    S_WAIT_CHAN = ST_WAIT_CHAN,
    S_UP        = ST_UP,
    S_BACKOFF   = ST_BACKOFF
  } state_e;

  // Bit positions of the core status inputs inside the synchroniser vector.
  localparam int SYNC_W     = 5;
  localparam int SYNC_LANE  = 0;
  localparam int SYNC_CHAN  = 1;
  localparam int SYNC_HARD  = 2;
  localparam int SYNC_SOFT  = 3;
  localparam int SYNC_FRAME = 4;

  // Larger of two parameter values, used to size the shared cycle timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aurora_sync2.sv
// Two-flop synchroniser bringing asynchronous core status into INIT_CLK.
module aurora_sync2 #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Two-stage capture; the first stage may go metastable, the second is used.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/aurora_link_init_ctrl.sv
// Bring-up/recovery sequencer for one Aurora lane: resets the core, waits for
// lane and channel up with timeouts, gates the frame generator and re-inits on errors.
module aurora_link_init_ctrl
  import aurora_ctrl_pkg::*;
#(
  parameter int unsigned GT_RST_CYCLES  = 16,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned LANE_TIMEOUT   = 65536,
  parameter int unsigned CHAN_TIMEOUT   = 65536,
  parameter int unsigned BACKOFF_CYCLES = 1024,
  parameter int unsigned SOFT_ERR_LIMIT = 4,
  parameter int unsigned ERR_WINDOW     = 4096
) (
  input  logic               i_init_clk,
  input  logic               i_reset,
  input  logic               i_force_reinit,
  input  logic               i_lane_up,
  input  logic               i_channel_up,
  input  logic               i_hard_err,
  input  logic               i_soft_err,
  input  logic               i_frame_err,
  output logic               o_gt_reset_out,
  output logic               o_reset_out,
  output logic               o_gen_en,
  output logic               o_link_ok,
  output logic [7:0]         o_retry_cnt,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned MAX_P = max_u(max_u(max_u(GT_RST_CYCLES, RST_CYCLES),
                                              max_u(LANE_TIMEOUT, CHAN_TIMEOUT)),
                                        max_u(BACKOFF_CYCLES, ERR_WINDOW));
  localparam int TW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  // Wide enough for limit-1 plus two simultaneous events.
  localparam int CW = $clog2(SOFT_ERR_LIMIT + 2);

  localparam logic [TW-1:0] C_GT_LAST   = TW'(GT_RST_CYCLES - 1);
  localparam logic [TW-1:0] C_RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] C_LANE_LAST = TW'(LANE_TIMEOUT - 1);
  localparam logic [TW-1:0] C_CHAN_LAST = TW'(CHAN_TIMEOUT - 1);
  localparam logic [TW-1:0] C_BOFF_LAST = TW'(BACKOFF_CYCLES - 1);
  localparam logic [TW-1:0] C_WIN_LAST  = TW'(ERR_WINDOW - 1);
  localparam logic [CW-1:0] C_SOFT_LIM  = CW'(SOFT_ERR_LIMIT);
  localparam logic [7:0]    C_RETRY_MAX = 8'd255;

  logic [SYNC_W-1:0] w_sync;
  logic [1:0]        r_err_prev;
  logic [1:0]        w_err_rise;
  logic [CW-1:0]     w_soft_sum;
  logic              w_soft_trip;
  logic              w_win_wrap;
  logic              w_timer_clr;
  state_e            r_state;
  state_e            w_next_state;
  logic [TW-1:0]     r_timer;
  logic [CW-1:0]     r_soft_cnt;
  logic              r_gt_reset;
  logic              r_core_reset;
  logic              r_gen_en;
  logic              r_link_ok;
  logic [7:0]        r_retry_cnt;
  logic [STATE_W-1:0] r_state_out;

  aurora_sync2 #(.W(SYNC_W)) u_sync (
    .i_clk   (i_init_clk),
    .i_reset (i_reset),
    .i_d     ({i_frame_err, i_soft_err, i_hard_err, i_channel_up, i_lane_up}),
    .o_q     (w_sync)
  );

  // Soft and frame errors are counted as rising edges of their synchronised levels.
  assign w_err_rise  = {w_sync[SYNC_FRAME], w_sync[SYNC_SOFT]} & ~r_err_prev;
  assign w_soft_sum  = r_soft_cnt + CW'(w_err_rise[0]) + CW'(w_err_rise[1]);
  assign w_soft_trip = (w_soft_sum >= C_SOFT_LIM);
  assign w_win_wrap  = (r_timer == C_WIN_LAST);
  assign w_timer_clr = i_force_reinit || (w_next_state != r_state);

  // Next-state selection; a forced re-init overrides every state transition.
  always_comb begin
    w_next_state = r_state;
    if (i_force_reinit) begin
      w_next_state = S_GT_RST;
    end else begin
      case (r_state)
        S_GT_RST: begin
          if (r_timer == C_GT_LAST) w_next_state = S_RST;
          else                      w_next_state = S_GT_RST;
        end
        S_RST: begin
          if (r_timer == C_RST_LAST) w_next_state = S_WAIT_LANE;
          else                       w_next_state = S_RST;
        end
        S_WAIT_LANE: begin
          if (w_sync[SYNC_LANE])           w_next_state = S_WAIT_CHAN;
          else if (r_timer == C_LANE_LAST) w_next_state = S_BACKOFF;
          else                             w_next_state = S_WAIT_LANE;
        end
        S_WAIT_CHAN: begin
          if (w_sync[SYNC_CHAN])                                 w_next_state = S_UP;
          else if (!w_sync[SYNC_LANE] || r_timer == C_CHAN_LAST) w_next_state = S_BACKOFF;
          else                                                   w_next_state = S_WAIT_CHAN;
        end
        S_UP: begin
          if (w_sync[SYNC_HARD] || !w_sync[SYNC_CHAN] || w_soft_trip) w_next_state = S_BACKOFF;
          else                                                         w_next_state = S_UP;
        end
        S_BACKOFF: begin
          if (r_timer == C_BOFF_LAST) w_next_state = S_GT_RST;
          else                        w_next_state = S_BACKOFF;
        end
        default: w_next_state = S_GT_RST;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_init_clk) begin
    if (i_reset) r_state <= S_GT_RST;
    else         r_state <= w_next_state;
  end

  // Shared cycle timer: cleared on any state change, doubles as the UP error window.
  always_ff @(posedge i_init_clk) begin
    if (i_reset)                             r_timer <= '0;
    else if (w_timer_clr)                    r_timer <= '0;
    else if (r_state == S_UP && w_win_wrap)  r_timer <= '0;
    else                                     r_timer <= r_timer + 1'b1;
  end

  // Soft-error edge history and per-window count; count only lives while staying in UP.
  always_ff @(posedge i_init_clk) begin
    if (i_reset) begin
      r_err_prev <= 2'b00;
      r_soft_cnt <= '0;
    end else begin
      r_err_prev <= {w_sync[SYNC_FRAME], w_sync[SYNC_SOFT]};
      if (r_state == S_UP && w_next_state == S_UP) begin
        r_soft_cnt <= w_win_wrap ? '0 : w_soft_sum;
      end else begin
        r_soft_cnt <= '0;
      end
    end
  end

  // Registered outputs decoded from the next state; retry counts BACKOFF entries.
  always_ff @(posedge i_init_clk) begin
    if (i_reset) begin
      r_gt_reset   <= 1'b1;
      r_core_reset <= 1'b1;
      r_gen_en     <= 1'b0;
      r_link_ok    <= 1'b0;
      r_retry_cnt  <= 8'd0;
      r_state_out  <= ST_GT_RST;
    end else begin
      r_gt_reset   <= (w_next_state == S_GT_RST);
      r_core_reset <= (w_next_state == S_GT_RST) || (w_next_state == S_RST);
      r_gen_en     <= (w_next_state == S_UP);
      r_link_ok    <= (w_next_state == S_UP);
      r_state_out  <= w_next_state;
      if (w_next_state == S_BACKOFF && r_state != S_BACKOFF && r_retry_cnt != C_RETRY_MAX) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end else begin
        r_retry_cnt <= r_retry_cnt;
      end
    end
  end

  assign o_gt_reset_out = r_gt_reset;
  assign o_reset_out    = r_core_reset;
  assign o_gen_en       = r_gen_en;
  assign o_link_ok      = r_link_ok;
  assign o_retry_cnt    = r_retry_cnt;
  assign o_state        = r_state_out;

endmodule

// File: tb/tb_aurora_link_init_ctrl.sv
// Directed, scoreboard-based bench for aurora_link_init_ctrl.
module tb_aurora_link_init_ctrl;

  logic       clk;
  logic       i_reset;
  logic       i_force_reinit;
  logic       i_lane_up;
  logic       i_channel_up;
  logic       i_hard_err;
  logic       i_soft_err;
  logic       i_frame_err;
  logic       o_gt_reset_out;
  logic       o_reset_out;
  logic       o_gen_en;
  logic       o_link_ok;
  logic [7:0] o_retry_cnt;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;
  exp_t sb_q[$];

  aurora_link_init_ctrl #(
    .GT_RST_CYCLES  (16),
    .RST_CYCLES     (16),
    .LANE_TIMEOUT   (200),
    .CHAN_TIMEOUT   (200),
    .BACKOFF_CYCLES (50),
    .SOFT_ERR_LIMIT (4),
    .ERR_WINDOW     (256)
  ) dut (
    .i_init_clk     (clk),
    .i_reset        (i_reset),
    .i_force_reinit (i_force_reinit),
    .i_lane_up      (i_lane_up),
    .i_channel_up   (i_channel_up),
    .i_hard_err     (i_hard_err),
    .i_soft_err     (i_soft_err),
    .i_frame_err    (i_frame_err),
    .o_gt_reset_out (o_gt_reset_out),
    .o_reset_out    (o_reset_out),
    .o_gen_en       (o_gen_en),
    .o_link_ok      (o_link_ok),
    .o_retry_cnt    (o_retry_cnt),
    .o_state        (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL sb_empty: observed=%0d with no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic count_gt(output int n);
    n = 0;
    while (o_gt_reset_out === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic count_rst(output int n);
    n = 0;
    while (o_reset_out === 1'b1 && o_gt_reset_out === 1'b0 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic count_state(input logic [2:0] st, output int n);
    n = 0;
    while (o_state === st && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (o_state !== st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic soft_pulse();
    i_soft_err = 1'b1;
    tick();
    i_soft_err = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string pfx);
    push({pfx, "_gt"}, 1);    pop_check(int'(o_gt_reset_out));
    push({pfx, "_rst"}, 1);   pop_check(int'(o_reset_out));
    push({pfx, "_gen"}, 0);   pop_check(int'(o_gen_en));
    push({pfx, "_link"}, 0);  pop_check(int'(o_link_ok));
    push({pfx, "_retry"}, 0); pop_check(int'(o_retry_cnt));
    push({pfx, "_state"}, 0); pop_check(int'(o_state));
  endtask

  initial begin
    int n;
    int n_to;
    i_reset = 1'b1; i_force_reinit = 1'b0; i_lane_up = 1'b0; i_channel_up = 1'b0;
    i_hard_err = 1'b0; i_soft_err = 1'b0; i_frame_err = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");

    // Normal bring-up: LANE_UP at +40, CHANNEL_UP at +60 after reset release.
    i_reset = 1'b0;
    push("gt_len", 16);   count_gt(n);  pop_check(n);
    push("rst_len", 16);  count_rst(n); pop_check(n);
    push("wait_lane", 2); pop_check(int'(o_state));
    repeat (8) tick();
    i_lane_up = 1'b1;
    repeat (20) tick();
    push("wait_chan", 3); pop_check(int'(o_state));
    i_channel_up = 1'b1;
    push("up_latency", 3);
    n = 0;
    while (o_link_ok !== 1'b1 && n < 10) begin tick(); n++; end
    pop_check(n);
    push("up_gen", 1);    pop_check(int'(o_gen_en));
    push("up_state", 4);  pop_check(int'(o_state));
    push("up_retry", 0);  pop_check(int'(o_retry_cnt));

    // Single-cycle HARD_ERR in UP.
    push("hard_latency", 3);
    i_hard_err = 1'b1;
    tick();
    i_hard_err = 1'b0;
    n = 1;
    while (o_link_ok === 1'b1 && n < 10) begin tick(); n++; end
    pop_check(n);
    push("hard_state", 5); pop_check(int'(o_state));
    push("hard_retry", 1); pop_check(int'(o_retry_cnt));
    push("hard_gen", 0);   pop_check(int'(o_gen_en));
    push("backoff_len", 50); count_state(3'd5, n); pop_check(n);
    push("after_bo", 0);     pop_check(int'(o_state));
    wait_state(3'd4, 200);
    push("reup_state", 4); pop_check(int'(o_state));
    push("reup_retry", 1); pop_check(int'(o_retry_cnt));

    // Four soft-error edges in one window force re-init.
    repeat (4) soft_pulse();
    wait_state(3'd5, 10);
    push("soft4_state", 5); pop_check(int'(o_state));
    push("soft4_retry", 2); pop_check(int'(o_retry_cnt));

    // Three edges, window wrap, one more edge: link stays up.
    wait_state(3'd4, 300);
    push("soft_reup", 4); pop_check(int'(o_state));
    repeat (3) soft_pulse();
    repeat (260) tick();
    soft_pulse();
    repeat (10) tick();
    push("wrap_state", 4); pop_check(int'(o_state));
    push("wrap_link", 1);  pop_check(int'(o_link_ok));
    push("wrap_retry", 2); pop_check(int'(o_retry_cnt));

    // Loss of CHANNEL_UP in UP, then FORCE_REINIT while waiting for the channel.
    i_channel_up = 1'b0;
    wait_state(3'd5, 10);
    push("chan_loss_retry", 3); pop_check(int'(o_retry_cnt));
    wait_state(3'd3, 300);
    push("force_pre", 3); pop_check(int'(o_state));
    i_force_reinit = 1'b1;
    i_lane_up = 1'b0;
    tick();
    i_force_reinit = 1'b0;
    push("force_state", 0); pop_check(int'(o_state));
    push("force_retry", 3); pop_check(int'(o_retry_cnt));
    push("force_gt_len", 16); count_gt(n); pop_check(n);

    // LANE_UP never asserts: timeout, backoff, new attempt.
    push("nolane_rst_len", 16);  count_rst(n);          pop_check(n);
    push("nolane_wait", 200);    count_state(3'd2, n);  pop_check(n);
    push("nolane_state", 5);     pop_check(int'(o_state));
    push("nolane_retry", 4);     pop_check(int'(o_retry_cnt));
    push("nolane_bo_len", 50);   count_state(3'd5, n);  pop_check(n);
    push("nolane_regt", 0);      pop_check(int'(o_state));

    // 300 failed attempts (lane lost in WAIT_CHAN) saturate the retry counter.
    n_to = 0;
    i_lane_up = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_state(3'd3, 400);
      if (o_state !== 3'd3) n_to++;
      i_lane_up = 1'b0;
      wait_state(3'd5, 10);
      if (o_state !== 3'd5) n_to++;
      i_lane_up = 1'b1;
    end
    push("sat_timeouts", 0); pop_check(n_to);
    push("sat_retry", 255);  pop_check(int'(o_retry_cnt));
    repeat (10) tick();
    push("mid_backoff", 5);  pop_check(int'(o_state));

    // RESET mid-BACKOFF returns everything to reset values.
    i_reset = 1'b1;
    tick();
    check_reset_values("reset2");
    i_reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
